// File: rtl/hex_io_unit.sv
// hex_io_unit: CSR-mapped I/O port.
// Input side: 2-flop synchronizer + debounce for the 18 slide switches.
// Output side: sequential double-dabble binary-to-BCD conversion of CSR
// writes, driving eight active-low seven-segment displays with leading
// zeros blanked. A one-entry, latest-wins buffer holds a write that
// arrives while a conversion is running.
module hex_io_unit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] SW,
  output logic [31:0] sw_value,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7
);

  // Counter wide enough to hold DEBOUNCE_CYCLES itself (saturation value).
  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

  // ------------------------------------------------------------------
  // Switch path
  // ------------------------------------------------------------------
  logic [17:0]   s1_reg;
  logic [17:0]   s2_reg;
  logic [17:0]   s3_reg;
  logic [CW-1:0] cnt_reg;
  logic [17:0]   sw_value_reg;

  // Synchronize, then accept s3 only after it has been stable for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg       <= '0;
      s2_reg       <= '0;
      s3_reg       <= '0;
      cnt_reg      <= '0;
      sw_value_reg <= '0;
    end else begin
      s1_reg <= SW;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
      if (s2_reg != s3_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + CW'(1);
      end
      if (cnt_reg == CNT_MAX) begin
        sw_value_reg <= s3_reg;
      end
    end
  end

  assign sw_value = {14'b0, sw_value_reg};

  // ------------------------------------------------------------------
  // Conversion control
  // ------------------------------------------------------------------
  state_t      state_reg;
  state_t      state_next;
  logic [31:0] bin_reg;
  logic [39:0] bcd_reg;
  logic [4:0]  it_reg;
  logic        pending_valid_reg;
  logic [31:0] pending_data_reg;

  logic        start_en;
  logic [31:0] start_data;
  logic        pend_wr;
  logic        pend_clr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic plus the start / pending-buffer control strobes.
  always_comb begin
    state_next = state_reg;
    start_en   = 1'b0;
    start_data = wr_data;
    pend_wr    = 1'b0;
    pend_clr   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (wr_en) begin
          start_en   = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        pend_wr = wr_en;
        if (it_reg == 5'd31) begin
          state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (pending_valid_reg) begin
          // Buffered value goes first; a write on this same edge refills the buffer.
          start_en   = 1'b1;
          start_data = pending_data_reg;
          pend_wr    = wr_en;
          pend_clr   = ~wr_en;
          state_next = ST_SHIFT;
        end else if (wr_en) begin
          start_en   = 1'b1;
          state_next = ST_SHIFT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Double-dabble datapath
  // ------------------------------------------------------------------
  logic [39:0] bcd_adj;

  // Add 3 to every BCD nibble that is 5 or more before the shift.
  generate
    for (genvar gi = 0; gi < 10; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  (bcd_reg[4*gi +: 4] + 4'd3) :
                                  bcd_reg[4*gi +: 4];
    end
  endgenerate

  // Load a new operand on start, otherwise shift one bit per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_reg <= '0;
      bcd_reg <= '0;
      it_reg  <= '0;
    end else if (start_en) begin
      bin_reg <= start_data;
      bcd_reg <= '0;
      it_reg  <= '0;
    end else if (state_reg == ST_SHIFT) begin
      {bcd_reg, bin_reg} <= {bcd_adj[38:0], bin_reg, 1'b0};
      it_reg             <= it_reg + 5'd1;
    end
  end

  // One-entry pending buffer; newest write overwrites older content.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_valid_reg <= 1'b0;
      pending_data_reg  <= '0;
    end else if (pend_wr) begin
      pending_valid_reg <= 1'b1;
      pending_data_reg  <= wr_data;
    end else if (pend_clr) begin
      pending_valid_reg <= 1'b0;
    end
  end

  assign busy = (state_reg != ST_IDLE) | pending_valid_reg;

  // ------------------------------------------------------------------
  // Segment encoding with leading-zero blanking
  // ------------------------------------------------------------------
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  logic [7:0] nz_upper;      // digit gi or any higher digit is nonzero
  logic [6:0] hex_enc [8];
  logic [6:0] hex_reg [8];

  // Only the low eight digits are shown; digits 9-10 are dropped (mod 10^8).
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_enc
      if (gi == 7) begin : g_top
        assign nz_upper[gi] = (bcd_reg[4*gi +: 4] != 4'd0);
      end else begin : g_low
        assign nz_upper[gi] = (bcd_reg[4*gi +: 4] != 4'd0) | nz_upper[gi+1];
      end
      if (gi == 0) begin : g_units
        // Units digit is never blanked so zero reads as "0".
        assign hex_enc[gi] = seg7(bcd_reg[4*gi +: 4]);
      end else begin : g_upper
        assign hex_enc[gi] = nz_upper[gi] ? seg7(bcd_reg[4*gi +: 4]) : SEG_BLANK;
      end
    end
  endgenerate

  // Display registers only change on the commit cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hex_reg[0] <= SEG_ZERO;
      for (int i = 1; i < 8; i++) begin
        hex_reg[i] <= SEG_BLANK;
      end
    end else if (state_reg == ST_COMMIT) begin
      for (int i = 0; i < 8; i++) begin
        hex_reg[i] <= hex_enc[i];
      end
    end
  end

  assign HEX0 = hex_reg[0];
  assign HEX1 = hex_reg[1];
  assign HEX2 = hex_reg[2];
  assign HEX3 = hex_reg[3];
  assign HEX4 = hex_reg[4];
  assign HEX5 = hex_reg[5];
  assign HEX6 = hex_reg[6];
  assign HEX7 = hex_reg[7];

endmodule

// File: tb/tb_hex_io_unit.sv
// Directed testbench for hex_io_unit.
module tb_hex_io_unit;

  logic        clk;
  logic        rst;
  logic [17:0] SW;
  logic [31:0] sw_value;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        busy;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic [55:0] hex_all;

  int passed = 0;
  int total  = 0;

  hex_io_unit #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .SW       (SW),
    .sw_value (sw_value),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .busy     (busy),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5),
    .HEX6     (HEX6),
    .HEX7     (HEX7)
  );

  assign hex_all = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Segment codes (active-low {g,f,e,d,c,b,a}).
  localparam logic [6:0] D0 = 7'h40, D1 = 7'h79, D2 = 7'h24, D3 = 7'h30, D4 = 7'h19;
  localparam logic [6:0] D5 = 7'h12, D6 = 7'h02, D7 = 7'h78, D8 = 7'h00, D9 = 7'h10;
  localparam logic [6:0] BL = 7'h7F;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_hex(input string tag, input logic [55:0] exp);
    logic [55:0] e;
    logic [55:0] o;
    e = exp;
    o = hex_all;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_HEX%0d", tag, i), {57'b0, o[7*i +: 7]}, {57'b0, e[7*i +: 7]});
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic write_val(input logic [31:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Count samples with busy high (bounded), ending after busy falls.
  task automatic wait_done(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;
  int first_idx, second_idx, gaps, sevens;

  initial begin
    rst = 1'b1; SW = '0; wr_en = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_sw_value", {32'b0, sw_value}, 64'd0);
    check_hex("rst", {BL, BL, BL, BL, BL, BL, BL, D0});
    rst = 1'b0;
    repeat (10) @(negedge clk);
    $display("step: reset released");

    // 12345 from IDLE
    write_val(32'd12345);
    wait_done(n);
    check("busy_len_12345", n, 33);
    check_hex("v12345", {BL, BL, BL, D1, D2, D3, D4, D5});
    $display("step: wrote 12345, busy cycles=%0d", n);

    // 0
    write_val(32'd0);
    wait_done(n);
    check("busy_len_0", n, 33);
    check_hex("v0", {BL, BL, BL, BL, BL, BL, BL, D0});
    $display("step: wrote 0");

    // 4294967295 -> 94967295
    write_val(32'hFFFF_FFFF);
    wait_done(n);
    check("busy_len_max", n, 33);
    check_hex("vmax", {D9, D4, D9, D6, D7, D2, D9, D5});
    $display("step: wrote 4294967295");

    // Writes during SHIFT: 8, then 7 and 3 back to back (7 overwritten)
    first_idx = -1; second_idx = -1; gaps = 0; sevens = 0;
    write_val(32'd8);
    for (int i = 0; i < 80; i++) begin
      if (HEX0 === D8 && first_idx < 0) first_idx = i;
      if (HEX0 === D3 && second_idx < 0) second_idx = i;
      if (HEX0 === D7) sevens++;
      if (second_idx < 0 && busy !== 1'b1) gaps++;
      if (i == 5) begin
        wr_en = 1'b1; wr_data = 32'd7;
      end else if (i == 6) begin
        wr_data = 32'd3;
      end else if (i == 7) begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    check("first_commit_idx", first_idx, 33);
    check("second_commit_idx", second_idx, 66);
    check("busy_gaps", gaps, 0);
    check("seven_shown", sevens, 0);
    check("busy_after_pair", {63'b0, busy}, 64'd0);
    check_hex("v3", {BL, BL, BL, BL, BL, BL, BL, D3});
    $display("step: back-to-back commits at %0d and %0d", first_idx, second_idx);

    // Reset at E10 of a conversion of 99
    write_val(32'd99);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check_hex("midrst", {BL, BL, BL, BL, BL, BL, BL, D0});
    repeat (40) @(negedge clk);
    check("midrst_busy_late", {63'b0, busy}, 64'd0);
    check_hex("midrst_late", {BL, BL, BL, BL, BL, BL, BL, D0});
    $display("step: reset during conversion");

    // Switch latency: visible after E8, not before
    SW = 18'h1DDDD;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("sw_after_E%0d", k), {32'b0, sw_value},
            (k == 8) ? 64'h1DDDD : 64'h0);
    end
    $display("step: switch 0 -> 1DDDD");

    // Glitch on bit 0 for 2 cycles
    SW = 18'h1DDDC;
    repeat (2) @(negedge clk);
    SW = 18'h1DDDD;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("glitch_%0d", k), {32'b0, sw_value}, 64'h1DDDD);
      @(negedge clk);
    end
    $display("step: switch glitch");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hex_io_unit.md
# hex_io_unit

Memory-mapped I/O port between the CPU's CSR datapath and the board's switches and seven-segment displays. The input side synchronizes and debounces the 18 slide switches and presents a stable value for CSR reads. The output side accepts 32-bit CSR writes and converts each to unsigned decimal with a sequential 32-iteration double-dabble engine. It then drives HEX0..HEX7 with active-low segment codes and blanks leading zeros.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required before `sw_value` updates (>=1).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- SW  in  18  raw slide switches, asynchronous to clk.
- sw_value  out  32  debounced switches, zero-extended ({14'b0, sw}).
- wr_en  in  1  one-cycle write strobe from the CSR write stage.
- wr_data  in  32  unsigned value to display.
- busy  out  1  conversion in progress or pending.
- HEX0..HEX7  out  7 each  segment codes {g,f,e,d,c,b,a}, active-low; HEX0 = least significant digit.

## Operation
- **Switch path**
  - `s1` and `s2` form a 2-flop synchronizer; `s3` is `s2` delayed one cycle.
  - Counter `cnt`: cleared when `s2 != s3`, otherwise increments, saturating at DEBOUNCE_CYCLES.
  - When `cnt == DEBOUNCE_CYCLES`, `sw_value <= s3`.
- **Conversion FSM: IDLE, SHIFT, COMMIT**
  - IDLE: on `wr_en`, load `bin <= wr_data`, `bcd` (40 bits) `<= 0`, `it <= 0`, go to SHIFT.
  - SHIFT: once per cycle, add 3 to every BCD nibble >= 5, then shift `{bcd,bin}` left 1. `it` increments; after the edge where `it == 31`, go to COMMIT.
  - COMMIT: latch the low 8 BCD digits into the HEX registers through the encoder. Digits 9-10 are discarded, so the display shows value mod 10^8.
    - If `pending_valid`: start `pending_data` (as in IDLE) and go to SHIFT.
    - Else if `wr_en`: start `wr_data` and go to SHIFT.
    - Else go to IDLE.
- **Pending buffer (one entry, latest wins)**
  - `wr_en` during SHIFT, or during COMMIT while `pending_valid`, writes `pending_data <= wr_data` and sets `pending_valid`, overwriting any older pending value.
  - `pending_valid` is cleared when its value is started, except when the same COMMIT edge also writes a new value into it.
  - Writes are never dropped except by overwrite.
- **busy** = (state != IDLE) | `pending_valid`.
- **Encoder (active-low)**: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Blank = 1111111.
- **Leading-zero blanking**: every digit above the most significant nonzero digit is blank. HEX0 always shows a digit, so value 0 shows "0".

## Timing
- **Reset values**: `sw_value` = 0, `s1`/`s2`/`s3`/`cnt` = 0, state IDLE, `busy` = 0, `pending_valid` = 0, HEX0 = 1000000, HEX1..HEX7 = 1111111.
- **Reset mid-operation**: the conversion is aborted, pending is discarded, and outputs take their reset values at that edge.
- **Write latency**:
  - Accept edge E0 (`wr_en` sampled in IDLE).
  - Shift edges E1..E32.
  - Commit edge E33: HEX outputs are valid after E33 and hold until the next commit.
  - `busy` rises after E0 and falls after E33 if nothing is pending.
- **Back-to-back**: a pending value starts at the commit edge, so its HEX update lands 33 cycles after the previous one.
- **HEX outputs** are registered; they never show intermediate BCD.
- **Switch latency**: an SW change that is stable before edge E1 reaches `sw_value` after edge E(DEBOUNCE_CYCLES+4), i.e. after E8 at the default.
- **Glitch rejection**: a change that reverts before `cnt` reaches DEBOUNCE_CYCLES never reaches `sw_value`.
- **Idle behaviour**: `sw_value` is held constant while SW is steady; `busy` does not affect the switch path.

## Test plan
- Reset, then write 12345 in IDLE.
  - Stimulus: `wr_en` pulse with `wr_data` = 12345.
  - Required: `busy` = 1 for exactly 33 cycles. After E33: HEX0=0010010, HEX1=0011001, HEX2=0110000, HEX3=0100100, HEX4=1111001, HEX5..HEX7=1111111.
- Write 0, then 4294967295.
  - Required after 0: HEX0=1000000, HEX1..HEX7 blank.
  - Required after 4294967295: displays 94967295, i.e. HEX7=0010000, HEX6=0011001, HEX5=0010000, HEX4=0000010, HEX3=1111000, HEX2=0100100, HEX1=0010000, HEX0=0010010.
- Writes during SHIFT.
  - Stimulus: write 8, then 7 and 3 on consecutive cycles during SHIFT.
  - Required: HEX0 shows 8, then 3 (7 is overwritten), with commits 33 cycles apart; `busy` is continuous.
- Reset during conversion.
  - Stimulus: write 99 and assert `rst` at E10.
  - Required: HEX returns to reset pattern, `busy` = 0, 99 never displayed.
- Switch debounce and latency.
  - Stimulus: SW 0 -> 18'h1DDDD held.
  - Required: `sw_value` = 32'h0001DDDD after E8, not before.
- Switch glitch rejection.
  - Stimulus: toggle SW bit 0 for 2 cycles, then restore.
  - Required: `sw_value` unchanged throughout.
